mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the EX stage of the pipelined MIPS datapath.
- Executes mult/multu/div/divu/madd over a configurable number of cycles and exposes busy so the hazard unit can stall dependent HI/LO accesses.
- Implements mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles busy is high for mult/multu/madd (>=1).
- DIV_CYCLES, 10, cycles busy is high for div/divu (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request strobe; qualifies op for one cycle.
- op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (signed).
- A  input  WIDTH  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  WIDTH  operand rt (divisor / multiplier).
- rd_sel  input  1  0 selects LO, 1 selects HI for rd_data.
- busy  output  1  long operation in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- rd_data  output  WIDTH  combinational mfhi/mflo read: rd_sel ? HI : LO.

Behaviour:
- Reset (reset==0, any time, asynchronous): HI=0, LO=0, busy=0, counter=0; any in-flight operation is discarded and HI/LO keep no partial result.
- States: IDLE and RUN. busy is 1 exactly in RUN.
- IDLE, start=1, op in {1,2,3,4,7}:
  - On the edge, operands and op are captured and the result is computed into internal shadow registers.
  - Counter loads MULT_CYCLES (ops 1, 2, 7) or DIV_CYCLES (ops 3, 4); state goes to RUN.
- RUN: counter decrements each edge. On the edge where counter==1, HI/LO take the shadow result, busy drops and state returns to IDLE. busy is therefore high for exactly N cycles after the accepting edge.
- IDLE, start=1, op=5/6: HI (op 5) or LO (op 6) is written with A on that edge; busy stays 0.
- start with op=0, or any start while busy=1: ignored, with no queuing; the hazard unit must not issue in that case.
- Arithmetic:
  - MULT: {HI,LO} = signed A × signed B, 2·WIDTH-bit product.
  - MULTU: {HI,LO} = unsigned A × unsigned B.
  - MADD: {HI,LO} = {HI,LO} + signed A × signed B, mod 2^(2·WIDTH). The HI/LO values used are those at the accepting edge.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient to LO, unsigned remainder to HI.
- DIV overflow (A = most-negative value, B = -1): LO = A, HI = 0; no trap.
- Divide by zero (B=0, DIV or DIVU): runs the full DIV_CYCLES, then HI/LO are left unchanged.
- HI/LO outputs show committed values only; shadow results are never visible while busy=1.
- rd_data is purely combinational with zero latency. A same-cycle mthi/mtlo is visible only after the edge.
- Reset deasserting mid-cycle: the first accepted start is on the first rising edge with reset==1.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 at edge 0 -> busy high cycles 1..5, falls at edge 5; HI=0xFFFFFFFF, LO=0xFFFFFFFA; rd_sel=1 gives rd_data=0xFFFFFFFF.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678 with no busy -> HI=0x12345678 next edge, busy stays 0. Then DIV by B=0 -> busy 10 cycles, HI=0x12345678 and LO unchanged afterwards.
- HI=0, LO=0xFFFFFFFF, then MADD A=1, B=1 -> HI=1, LO=0 (carry from LO into HI). DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIV, assert MTLO and MULT while busy -> both ignored, DIV result commits. Separately, pull reset low at cycle 4 of a DIV -> HI=LO=0, busy=0 immediately, no later commit.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Rev 1.0 - initial release.
`default_nettype none

module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             rd_sel,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  localparam logic [CW-1:0]    MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_N  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shadow_hi;
  logic [WIDTH-1:0] shadow_lo;

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [WIDTH-1:0]   sq, sr, q_s, r_s, q_u, r_u;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               long_op;

  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zx   = {{WIDTH{1'b0}}, A};
  assign b_zx   = {{WIDTH{1'b0}}, B};
  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide via magnitudes; most-negative / -1 wraps back to A with remainder 0.
  assign a_neg      = A[WIDTH-1];
  assign b_neg      = B[WIDTH-1];
  assign a_mag      = a_neg ? -A : A;
  assign b_mag      = b_neg ? -B : B;
  assign b_mag_safe = (b_mag == '0) ? ONE : b_mag;
  assign b_u_safe   = (B == '0) ? ONE : B;
  assign sq         = a_mag / b_mag_safe;
  assign sr         = a_mag % b_mag_safe;
  assign q_s        = (a_neg ^ b_neg) ? -sq : sq;
  assign r_s        = a_neg ? -sr : sr;
  assign q_u        = A / b_u_safe;
  assign r_u        = A % b_u_safe;

  assign long_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                   (op == OP_DIV)  || (op == OP_DIVU);

  // Divide by zero leaves the current HI/LO in the shadow; no writes can land while busy.
  always_comb begin
    res_hi = HI;
    res_lo = LO;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_MADD:  {res_hi, res_lo} = {HI, LO} + prod_s;
      OP_DIV:   if (B != '0) begin res_hi = r_s; res_lo = q_s; end
      OP_DIVU:  if (B != '0) begin res_hi = r_u; res_lo = q_u; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      HI        <= '0;
      LO        <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (long_op) begin
              shadow_hi <= res_hi;
              shadow_lo <= res_lo;
              count     <= ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_N : MULT_N;
              state     <= RUN;
              busy      <= 1'b1;
            end else if (op == OP_MTHI) begin
              HI <= A;
            end else if (op == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          if (count <= 1) begin
            HI    <= shadow_hi;
            LO    <= shadow_lo;
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = rd_sel ? HI : LO;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit with a queue-based scoreboard on busy-falling commits.
`default_nettype none

module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        rd_sel;
  logic        busy;
  logic [31:0] HI, LO, rd_data;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .rd_sel(rd_sel), .busy(busy), .HI(HI), .LO(LO), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cycles;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  // Monitor: a falling busy is the commit; compare it against the oldest expectation.
  int    busy_cnt = 0;
  logic  prev_busy = 1'b0;
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit actual HI=0x%08h LO=0x%08h expected none", HI, LO);
        end else begin
          mon_e = exp_q.pop_front();
          mon_n = name_q.pop_front();
          check({mon_n, "_busy_cycles"}, busy_cnt, mon_e.cycles);
          check({mon_n, "_HI"}, HI, mon_e.hi);
          check({mon_n, "_LO"}, LO, mon_e.lo);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
  endtask

  task automatic long_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cycles = cyc;
    exp_q.push_back(e);
    name_q.push_back(name);
    issue(o, a, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual busy=1 after %0d cycles expected 0", n);
    end
    @(negedge clk);
  endtask

  initial begin
    logic saw_busy;
    reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_HI", HI, 32'h0);
    check("reset_LO", LO, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // MULT -2 * 3; shadow result must stay hidden while busy.
    long_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    check("mult_busy_now", {31'd0, busy}, 32'd1);
    check("mult_HI_hidden", HI, 32'h0);
    wait_idle();
    rd_sel = 1'b1; #1;
    check("rd_hi", rd_data, 32'hFFFFFFFF);
    rd_sel = 1'b0; #1;
    check("rd_lo", rd_data, 32'hFFFFFFFA);

    long_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    wait_idle();
    long_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle();
    long_op("div_negb", 3'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    wait_idle();
    long_op("divu", 3'd4, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 10);
    wait_idle();

    issue(3'd5, 32'h12345678, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_HI", HI, 32'h12345678);
    long_op("div_by_zero", 3'd3, 32'd99, 32'd0, 32'h12345678, 32'h7FFFFFFC, 10);
    wait_idle();

    issue(3'd5, 32'h0, 32'd0);
    issue(3'd6, 32'hFFFFFFFF, 32'd0);
    check("mtlo_LO", LO, 32'hFFFFFFFF);
    long_op("madd_carry", 3'd7, 32'd1, 32'd1, 32'h00000001, 32'h00000000, 5);
    wait_idle();
    long_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    wait_idle();
    // {0,0x80000000} + (-1 * -2^31) = 0x1_0000_0000
    long_op("madd_neg", 3'd7, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000, 5);
    wait_idle();

    // Requests while busy are dropped.
    long_op("div_ignore", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    issue(3'd6, 32'hDEADBEEF, 32'd0);
    issue(3'd1, 32'd3, 32'd3);
    wait_idle();

    // Asynchronous reset in the middle of a divide.
    issue(3'd3, 32'd50, 32'd5);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_HI", HI, 32'h0);
    check("rst_mid_LO", LO, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_busy = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("rst_no_resume", {31'd0, saw_busy}, 32'd0);
    check("rst_after_HI", HI, 32'h0);
    check("rst_after_LO", LO, 32'h0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
